final_layer_feeder: RTL

- Front end of the sequential final (classifier) layer.
- Accepts a byte stream carrying the 10 neuron weight vectors and the flattened activation vector, and assembles them into NUM_INPUTS-wide registers.
- Drives the final layer's enable for a fixed evaluation window, captures the 4-bit class answer, and presents it with a valid flag.
- Weights may be retained across inferences, so only activations are reloaded.

---
 rtl/final_layer_feeder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/final_layer_feeder.sv
// rtl/final_layer_feeder.sv - byte-stream loader and run sequencer for the final classifier layer
// Assembles weight/activation vectors from bytes, enables the layer for two cycles, captures its answer.
module final_layer_feeder #(
  parameter int NUM_INPUTS  = 196,
  parameter int NUM_NEURONS = 10
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_load_weights,
  input  logic [7:0]            i_s_data,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  output logic                  o_layer_en,
  output logic [NUM_INPUTS-1:0] o_data_out,
  output logic [NUM_INPUTS-1:0] o_weights_out [NUM_NEURONS-1:0],
  input  logic [3:0]            i_answer_in,
  input  logic                  i_layer_done_in,
  output logic [3:0]            o_result,
  output logic                  o_result_valid,
  output logic                  o_busy,
  output logic                  o_layer_done_flag
);

  localparam int BPV = (NUM_INPUTS + 7) / 8;
  localparam int BCW = (BPV > 1) ? $clog2(BPV) : 1;
  localparam logic [BCW-1:0] LAST_BYTE   = BCW'(BPV - 1);
  localparam logic [3:0]     LAST_NEURON = 4'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_D,
    S_RUN,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [BCW-1:0]        r_byte_cnt;
  logic [3:0]            r_neuron_cnt;
  logic                  r_run_cnt;
  logic                  r_weights_valid;
  logic                  r_layer_done;
  logic [NUM_INPUTS-1:0] r_data;
  logic [NUM_INPUTS-1:0] r_weights [NUM_NEURONS-1:0];
  logic [3:0]            r_result;
  logic                  r_result_valid;

  logic                  w_s_ready;
  logic                  w_layer_en;
  logic                  w_busy;
  logic                  w_xfer;
  logic                  w_last_byte;
  logic                  w_start_ok;
  logic [BPV-1:0]        w_byte_sel;
  logic [NUM_INPUTS-1:0] w_mask;
  logic [NUM_INPUTS-1:0] w_spread;

  assign w_xfer      = i_s_valid & w_s_ready;
  assign w_last_byte = (r_byte_cnt == LAST_BYTE);
  assign w_start_ok  = i_start & ((r_state == S_IDLE) | (r_state == S_DONE));

  always_comb begin
    for (int j = 0; j < BPV; j++) begin
      w_byte_sel[j] = (r_byte_cnt == BCW'(j));
    end
  end

  // Each vector bit knows its byte lane; bits past NUM_INPUTS simply have no lane.
  for (genvar b = 0; b < NUM_INPUTS; b++) begin : g_lane
    assign w_mask[b]   = w_byte_sel[b / 8];
    assign w_spread[b] = i_s_data[b % 8];
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_s_ready  = 1'b0;
    w_layer_en = 1'b0;
    w_busy     = 1'b1;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_busy = 1'b0;
        if (i_start) begin
          w_next = (i_load_weights || !r_weights_valid) ? S_LOAD_W : S_LOAD_D;
        end
      end
      S_LOAD_W: begin
        w_s_ready = 1'b1;
        if (i_s_valid && w_last_byte && (r_neuron_cnt == LAST_NEURON)) begin
          w_next = S_LOAD_D;
        end
      end
      S_LOAD_D: begin
        w_s_ready = 1'b1;
        if (i_s_valid && w_last_byte) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        w_layer_en = 1'b1;
        if (r_run_cnt) begin
          w_next = S_DONE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_byte_cnt      <= '0;
      r_neuron_cnt    <= '0;
      r_run_cnt       <= 1'b0;
      r_weights_valid <= 1'b0;
      r_layer_done    <= 1'b0;
      r_data          <= '0;
      r_result        <= '0;
      r_result_valid  <= 1'b0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        r_weights[n] <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + 1'b1;
        if (r_state == S_LOAD_W) begin
          for (int n = 0; n < NUM_NEURONS; n++) begin
            if (r_neuron_cnt == 4'(n)) begin
              r_weights[n] <= (r_weights[n] & ~w_mask) | (w_spread & w_mask);
            end
          end
          if (w_last_byte) begin
            r_neuron_cnt <= (r_neuron_cnt == LAST_NEURON) ? '0 : r_neuron_cnt + 1'b1;
            if (r_neuron_cnt == LAST_NEURON) begin
              r_weights_valid <= 1'b1;
            end
          end
        end else begin
          r_data <= (r_data & ~w_mask) | (w_spread & w_mask);
          if (w_last_byte) begin
            r_run_cnt <= 1'b0;
          end
        end
      end
      // Second RUN cycle: the layer's answer is combinationally valid now.
      if (r_state == S_RUN) begin
        r_run_cnt <= ~r_run_cnt;
        if (r_run_cnt) begin
          r_result       <= i_answer_in;
          r_result_valid <= 1'b1;
          r_layer_done   <= i_layer_done_in;
        end
      end
      if (w_start_ok) begin
        r_result_valid <= 1'b0;
      end
    end
  end

  assign o_s_ready         = w_s_ready;
  assign o_layer_en        = w_layer_en;
  assign o_busy            = w_busy;
  assign o_data_out        = r_data;
  assign o_weights_out     = r_weights;
  assign o_result          = r_result;
  assign o_result_valid    = r_result_valid;
  assign o_layer_done_flag = r_layer_done;

endmodule
